// File: rtl/bk_sequencer_pkg.sv
// Shared types and constants for the backup-RAM sequencer.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } bk_state_e;

  // 512-byte sectors: byte mask bit 9 is the lowest sector-index bit.
  localparam int SECTOR_SHIFT = 9;

endpackage

// File: rtl/bk_sequencer_edge_det.sv
// Rise/fall detector against a registered previous value (reset to 0).
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_d;
  logic prev_q;

  // Next previous-value is simply the current input.
  always_comb begin
    prev_d = d;
  end

  // Hold the last sampled level.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/bk_sequencer.sv
// BSRAM save/load sequencer: arbitrates triggers and walks sectors through
// the hps_io SD sector handshake.
module bk_sequencer
  import bk_pkg::*;
#(
  parameter int LBA_BITS = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic [23:0] ram_mask,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_status,
  input  logic        bsram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        busy,
  output logic        dirty
);

  logic dl_rise, dl_fall;
  logic ld_rise, ld_fall_unused;
  logic sv_rise, sv_fall_unused;
  logic osd_rise, osd_fall_unused;
  logic ack_rise, ack_fall;

  edge_det u_dl_edge  (.clk(clk_sys), .reset(reset), .d(ioctl_download), .rise(dl_rise),  .fall(dl_fall));
  edge_det u_ld_edge  (.clk(clk_sys), .reset(reset), .d(load_req),       .rise(ld_rise),  .fall(ld_fall_unused));
  edge_det u_sv_edge  (.clk(clk_sys), .reset(reset), .d(save_req),       .rise(sv_rise),  .fall(sv_fall_unused));
  edge_det u_osd_edge (.clk(clk_sys), .reset(reset), .d(osd_status),     .rise(osd_rise), .fall(osd_fall_unused));
  edge_det u_ack_edge (.clk(clk_sys), .reset(reset), .d(sd_ack),         .rise(ack_rise), .fall(ack_fall));

  bk_state_e           state_d, state_q;
  logic [LBA_BITS-1:0] lba_d, lba_q;
  logic                rd_d, rd_q;
  logic                wr_d, wr_q;
  logic                ena_d, ena_q;
  logic                loading_d, loading_q;
  logic                dirty_d, dirty_q;

  logic [LBA_BITS-1:0] last;
  logic                load_trig;
  logic                save_trig;

  assign last      = ram_mask[LBA_BITS+SECTOR_SHIFT-1:SECTOR_SHIFT];
  assign load_trig = dl_fall | ld_rise;
  assign save_trig = sv_rise | (osd_rise & autosave_en & dirty_q);

  // Next-state logic: trigger arbitration, sector walk, dirty tracking, abort.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ena_d     = ena_q;
    loading_d = loading_q;
    dirty_d   = dirty_q;

    if (ioctl_download & img_mounted & img_size_nz & ~img_readonly)
      ena_d = |ram_mask;

    unique case (state_q)
      IDLE: begin
        if (ena_q && (load_trig || save_trig)) begin
          lba_d     = '0;
          loading_d = load_trig;
          rd_d      = load_trig;
          wr_d      = ~load_trig;
          state_d   = REQ;
          if (!load_trig) dirty_d = 1'b0;
        end
      end
      REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (lba_q >= last) begin
            loading_d = 1'b0;
            state_d   = IDLE;
            if (loading_q) dirty_d = 1'b0;
          end else begin
            // Direction of the running transfer is carried by loading_q.
            lba_d   = lba_q + {{(LBA_BITS-1){1'b0}}, 1'b1};
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the save-start clear so a coincident write keeps dirty set.
    if (bsram_we & ~loading_q) dirty_d = 1'b1;

    // Download start overrides everything, including a same-cycle trigger.
    if (dl_rise) begin
      state_d   = IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
      ena_d     = 1'b0;
    end
  end

  // Register all sequencer state and outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ena_q     <= 1'b0;
      loading_q <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ena_q     <= ena_d;
      loading_q <= loading_d;
      dirty_q   <= dirty_d;
    end
  end

  assign sd_lba     = {{(32-LBA_BITS){1'b0}}, lba_q};
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign busy       = (state_q != IDLE);
  assign dirty      = dirty_q;

endmodule

// File: tb/tb_bk_sequencer.sv
// Directed bench for bk_sequencer: load, save, autosave, gating, abort, reset.
module tb_bk_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        img_mounted;
  logic        img_readonly;
  logic        img_size_nz;
  logic [23:0] ram_mask;
  logic        load_req;
  logic        save_req;
  logic        autosave_en;
  logic        osd_status;
  logic        bsram_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_ena;
  logic        bk_loading;
  logic        busy;
  logic        dirty;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  bk_sequencer #(.LBA_BITS(8)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .img_mounted    (img_mounted),
    .img_readonly   (img_readonly),
    .img_size_nz    (img_size_nz),
    .ram_mask       (ram_mask),
    .load_req       (load_req),
    .save_req       (save_req),
    .autosave_en    (autosave_en),
    .osd_status     (osd_status),
    .bsram_we       (bsram_we),
    .sd_ack         (sd_ack),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .bk_ena         (bk_ena),
    .bk_loading     (bk_loading),
    .busy           (busy),
    .dirty          (dirty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Host side of one sector: the request must already be up with the given
  // direction and LBA; ack it, check the request drops next cycle, release.
  task automatic serve(input logic is_rd, input int unsigned lba);
    check("req_rd",  {31'd0, sd_rd}, {31'd0, is_rd});
    check("req_wr",  {31'd0, sd_wr}, {31'd0, ~is_rd});
    check("req_lba", sd_lba, lba);
    sd_ack = 1'b1;
    tick();
    check("ack_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
    check("ack_busy", {31'd0, busy}, 32'd1);
    tick();
    sd_ack = 1'b0;
    tick();
  endtask

  // Mount a save image during a download, then end the download.
  task automatic mount_and_finish(input logic ro, input logic [23:0] mask);
    ram_mask       = mask;
    img_readonly   = ro;
    ioctl_download = 1'b1;
    tick();
    img_mounted = 1'b1;
    tick();
    img_mounted    = 1'b0;
    ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size_nz = 1'b1; ram_mask = 24'h0; load_req = 1'b0; save_req = 1'b0;
    autosave_en = 1'b0; osd_status = 1'b0; bsram_we = 1'b0; sd_ack = 1'b0;
    tick(); tick();
    check("rst_out", {sd_lba[3:0], sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty}, 32'd0);
    reset = 1'b0;
    tick();

    // Download end with 2 KB mask: four sector reads, LBA 0..3.
    mount_and_finish(1'b0, 24'h0007FF);
    check("dl_ena",     {31'd0, bk_ena},     32'd1);
    check("dl_loading", {31'd0, bk_loading}, 32'd1);
    check("dl_busy",    {31'd0, busy},       32'd1);
    for (int unsigned s = 0; s < 4; s++) serve(1'b1, s);
    check("dl_done_loading", {31'd0, bk_loading}, 32'd0);
    check("dl_done_busy",    {31'd0, busy},       32'd0);

    // Single-sector save clears dirty at start.
    ram_mask = 24'h0001FF;
    bsram_we = 1'b1; tick(); bsram_we = 1'b0;
    check("we_dirty", {31'd0, dirty}, 32'd1);
    save_req = 1'b1;
    tick();
    check("sv_dirty_clr", {31'd0, dirty}, 32'd0);
    serve(1'b0, 0);
    check("sv_one_idle", {29'd0, busy, sd_rd, sd_wr}, 32'd0);
    save_req = 1'b0;
    tick();

    // Autosave on OSD open when dirty; a second open without writes does nothing.
    ram_mask = 24'h0007FF;
    autosave_en = 1'b1;
    bsram_we = 1'b1; tick(); bsram_we = 1'b0;
    osd_status = 1'b1;
    tick();
    for (int unsigned s = 0; s < 4; s++) serve(1'b0, s);
    check("as_idle", {31'd0, busy}, 32'd0);
    osd_status = 1'b0; tick();
    osd_status = 1'b1; tick();
    check("as_clean", {29'd0, busy, sd_rd, sd_wr}, 32'd0);
    osd_status = 1'b0; autosave_en = 1'b0;
    tick();

    // Load with a save request mid-transfer (dropped); load clears dirty.
    bsram_we = 1'b1; tick(); bsram_we = 1'b0;
    load_req = 1'b1;
    tick();
    check("ld_start", {30'd0, sd_rd, sd_wr}, 32'd2);
    serve(1'b1, 0);
    save_req = 1'b1;
    bsram_we = 1'b1;
    for (int unsigned s = 1; s < 4; s++) begin
      serve(1'b1, s);
      bsram_we = 1'b0;
    end
    check("ld_idle",  {30'd0, busy, bk_loading}, 32'd0);
    check("ld_dirty", {31'd0, dirty}, 32'd0);
    load_req = 1'b0; save_req = 1'b0;
    tick();

    // Download start during sector 2 of a save aborts it.
    save_req = 1'b1;
    tick();
    serve(1'b0, 0);
    serve(1'b0, 1);
    check("ab_sec2", {30'd0, sd_rd, sd_wr}, 32'd1);
    ioctl_download = 1'b1;
    tick();
    check("ab_out", {29'd0, sd_wr, busy, bk_ena}, 32'd0);
    ioctl_download = 1'b0;
    tick();
    check("ab_no_load", {30'd0, sd_rd, busy}, 32'd0);
    save_req = 1'b0;
    tick();

    // Read-only image or no save RAM: never enabled, requests ignored.
    for (int unsigned c = 0; c < 2; c++) begin
      mount_and_finish((c == 0), (c == 0) ? 24'h0007FF : 24'h000000);
      check("gate_ena", {31'd0, bk_ena}, 32'd0);
      load_req = 1'b1; tick();
      check("gate_ld", {29'd0, busy, sd_rd, sd_wr}, 32'd0);
      load_req = 1'b0; save_req = 1'b1; tick();
      check("gate_sv", {29'd0, busy, sd_rd, sd_wr}, 32'd0);
      save_req = 1'b0; tick();
    end

    // Reset mid-transfer with ack still high returns to idle and stays there.
    mount_and_finish(1'b0, 24'h0007FF);
    check("rs_start", {31'd0, sd_rd}, 32'd1);
    sd_ack = 1'b1; tick();
    reset = 1'b1; tick();
    check("rs_out", {26'd0, sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty}, 32'd0);
    reset = 1'b0; tick();
    sd_ack = 1'b0; tick(); tick();
    check("rs_quiet", {29'd0, busy, sd_rd, sd_wr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
